// File: rtl/fir_mac_core_if.sv
// Stream and coefficient-port bundle for the shared-multiplier FIR core.
// The core sits on the slave side; whatever feeds samples and coefficients
// and consumes results uses the master side.
interface fir_mac_core_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 8,
    parameter int AW     = 3
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_we;
    logic        [AW-1:0]     coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     busy;

    modport master (
        output flush, in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  flush, in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fir_mac_core.sv
// Coefficient-programmable FIR filter built around a single multiplier.
// Each accepted sample is shifted into the delay line and then TAPS
// multiply-accumulate cycles run, one tap per clock. The accumulator is
// rounded half-up, arithmetically shifted and saturated into the result.
module fir_mac_core #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 7
) (
    input  logic clk,
    input  logic rst,
    fir_mac_core_if.slave bus
);
    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + AW;
    localparam int RND_W  = ACC_W + 1;

    localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);

    // Rounding constant is half an output LSB; zero when no shift is applied.
    localparam int ROUND_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 0;
    localparam logic signed [RND_W-1:0] ROUND_W = RND_W'(ROUND_I);

    localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] OUT_MIN = -OUT_MAX - RND_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_x [TAPS];
    logic signed [COEF_W-1:0]  r_c [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic        [AW-1:0]      r_tap;
    logic signed [OUT_W-1:0]   r_outData;
    logic                      r_outValid;

    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_accNext;
    logic signed [RND_W-1:0]   w_rounded;
    logic signed [RND_W-1:0]   w_shifted;
    logic signed [OUT_W-1:0]   w_clamped;
    logic                      w_coefAddrOk;

    // One tap of the dot product, plus the rounded and saturated view of the
    // accumulator as it will stand after this tap.
    always_comb begin
        w_prod       = r_x[r_tap] * r_c[r_tap];
        w_accNext    = r_acc + ACC_W'(w_prod);
        w_rounded    = RND_W'(w_accNext) + ROUND_W;
        w_shifted    = w_rounded >>> SHIFT;
        w_coefAddrOk = (int'(bus.coef_addr) < TAPS);
        w_clamped    = w_shifted[OUT_W-1:0];
        if (w_shifted > OUT_MAX) begin
            w_clamped = OUT_MAX[OUT_W-1:0];
        end else if (w_shifted < OUT_MIN) begin
            w_clamped = OUT_MIN[OUT_W-1:0];
        end
    end

    // Sequencer: accept a sample, walk the taps, then hold the result until taken.
    // Coefficient writes are only honoured while idle so a sample in flight
    // always sees one consistent coefficient set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_tap      <= '0;
            r_outData  <= '0;
            r_outValid <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
                r_c[k] <= '0;
            end
        end else if (bus.flush) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_tap      <= '0;
            r_outValid <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.coef_we && w_coefAddrOk) begin
                        r_c[bus.coef_addr] <= bus.coef_wdata;
                    end
                    if (bus.in_valid) begin
                        r_x[0] <= bus.in_data;
                        for (int k = 1; k < TAPS; k++) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_acc   <= '0;
                        r_tap   <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= w_accNext;
                    r_tap <= r_tap + 1'b1;
                    if (r_tap == TAP_LAST) begin
                        r_tap      <= '0;
                        r_outData  <= w_clamped;
                        r_outValid <= 1'b1;
                        r_state    <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;

endmodule

// File: tb/tb_fir_mac_core.sv
// Bench for fir_mac_core. Two cores run in lockstep on identical inputs,
// one with no output shift and one with a shift of 7, so every transaction
// exercises both the saturating and the rounding result paths.
module tb_fir_mac_core;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 8;
    localparam int OUT_W  = 8;
    localparam int AW     = $clog2(TAPS);

    logic clk = 1'b0;
    logic rst;

    int nChecks = 0;
    int nFail   = 0;

    // Reference state: plain integer history and coefficient arrays.
    int mHist [TAPS];
    int mCoef [TAPS];

    typedef struct {
        logic signed [7:0] sample;
        logic signed [7:0] exp0;
        logic signed [7:0] exp7;
    } vec_t;

    vec_t impulseTab [9];
    vec_t satPosTab  [8];
    vec_t satNegTab  [8];
    vec_t roundTab   [6];

    fir_mac_core_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .AW(AW)) bus0 ();
    fir_mac_core_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .AW(AW)) bus7 ();

    fir_mac_core #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fir_mac_core #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(7))
        dut7 (.clk(clk), .rst(rst), .bus(bus7));

    assign bus7.flush      = bus0.flush;
    assign bus7.in_valid   = bus0.in_valid;
    assign bus7.in_data    = bus0.in_data;
    assign bus7.coef_we    = bus0.coef_we;
    assign bus7.coef_addr  = bus0.coef_addr;
    assign bus7.coef_wdata = bus0.coef_wdata;
    assign bus7.out_ready  = bus0.out_ready;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int modelResult(input longint acc, input int sh);
        longint r;
        r = acc;
        if (sh > 0) begin
            r = (acc + (longint'(1) << (sh - 1))) >>> sh;
        end
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic modelAccept(input int d, output int e0, output int e7);
        longint acc;
        for (int k = TAPS - 1; k > 0; k--) begin
            mHist[k] = mHist[k-1];
        end
        mHist[0] = d;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            acc += longint'(mHist[k]) * longint'(mCoef[k]);
        end
        e0 = modelResult(acc, 0);
        e7 = modelResult(acc, 7);
    endtask

    task automatic modelFlush();
        for (int k = 0; k < TAPS; k++) mHist[k] = 0;
    endtask

    task automatic modelReset();
        for (int k = 0; k < TAPS; k++) begin
            mHist[k] = 0;
            mCoef[k] = 0;
        end
    endtask

    // Coefficient write issued while the cores are idle.
    task automatic writeCoef(input int addr, input int val);
        bus0.coef_we    = 1'b1;
        bus0.coef_addr  = AW'(addr);
        bus0.coef_wdata = COEF_W'(val);
        mCoef[addr]     = val;
        tick();
        bus0.coef_we = 1'b0;
    endtask

    task automatic setAllCoefs(input int val);
        for (int k = 0; k < TAPS; k++) writeCoef(k, val);
    endtask

    task automatic doFlush();
        bus0.flush = 1'b1;
        tick();
        bus0.flush = 1'b0;
        modelFlush();
    endtask

    // Offer one sample from idle, wait for its result, optionally stall the
    // consumer, then take the result. Expected values come from the table when
    // useTab is set, otherwise from the reference model.
    task automatic applyStimulus(input logic signed [7:0] d, input bit useTab,
                                 input logic signed [7:0] t0, input logic signed [7:0] t7,
                                 input int stall, input string tag);
        int e0, e7, n;
        checkOutput({tag, " in_ready"}, int'(bus0.in_ready), 1);
        bus0.in_valid  = 1'b1;
        bus0.in_data   = d;
        bus0.out_ready = (stall == 0);
        modelAccept(int'(d), e0, e7);
        if (useTab) begin
            e0 = int'(t0);
            e7 = int'(t7);
        end
        tick();
        bus0.in_valid = 1'b0;
        bus0.coef_we  = 1'b0;
        n = 0;
        while (!bus0.out_valid && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, " latency"}, n, TAPS);
        repeat (stall) tick();
        checkOutput({tag, " out0"}, int'(bus0.out_data), e0);
        checkOutput({tag, " out7"}, int'(bus7.out_data), e7);
        bus0.out_ready = 1'b1;
        tick();
        checkOutput({tag, " out_valid drop"}, int'(bus0.out_valid), 0);
        checkOutput({tag, " idle after"}, int'(bus0.busy), 0);
    endtask

    // Accept a sample, then interrupt it three cycles into the accumulation.
    task automatic startAndAdvance(input logic signed [7:0] d);
        int e0, e7;
        bus0.in_valid = 1'b1;
        bus0.in_data  = d;
        modelAccept(int'(d), e0, e7);
        tick();
        bus0.in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic expectNoOutput(input string tag);
        int seen;
        seen = 0;
        repeat (TAPS + 3) begin
            tick();
            if (bus0.out_valid || bus7.out_valid) seen = 1;
        end
        checkOutput({tag, " no stray out_valid"}, seen, 0);
    endtask

    initial begin
        int e0, e7, st;
        logic signed [7:0] rd;

        impulseTab = '{
            '{8'sd1, 8'sd1, 8'sd0}, '{8'sd0, 8'sd2, 8'sd0}, '{8'sd0, 8'sd3, 8'sd0},
            '{8'sd0, 8'sd4, 8'sd0}, '{8'sd0, 8'sd5, 8'sd0}, '{8'sd0, 8'sd6, 8'sd0},
            '{8'sd0, 8'sd7, 8'sd0}, '{8'sd0, 8'sd8, 8'sd0}, '{8'sd0, 8'sd0, 8'sd0}
        };
        satPosTab = '{
            '{8'sd127, 8'sd127, 8'sd126}, '{8'sd127, 8'sd127, 8'sd127},
            '{8'sd127, 8'sd127, 8'sd127}, '{8'sd127, 8'sd127, 8'sd127},
            '{8'sd127, 8'sd127, 8'sd127}, '{8'sd127, 8'sd127, 8'sd127},
            '{8'sd127, 8'sd127, 8'sd127}, '{8'sd127, 8'sd127, 8'sd127}
        };
        satNegTab = '{
            '{-8'sd128, -8'sd128, -8'sd127}, '{-8'sd128, -8'sd128, -8'sd128},
            '{-8'sd128, -8'sd128, -8'sd128}, '{-8'sd128, -8'sd128, -8'sd128},
            '{-8'sd128, -8'sd128, -8'sd128}, '{-8'sd128, -8'sd128, -8'sd128},
            '{-8'sd128, -8'sd128, -8'sd128}, '{-8'sd128, -8'sd128, -8'sd128}
        };
        roundTab = '{
            '{8'sd3,  8'sd127,  8'sd2},  '{-8'sd3, -8'sd128, -8'sd1},
            '{8'sd1,  8'sd64,   8'sd1},  '{-8'sd1, -8'sd64,   8'sd0},
            '{8'sd2,  8'sd127,  8'sd1},  '{8'sd0,   8'sd0,    8'sd0}
        };

        rst             = 1'b1;
        bus0.flush      = 1'b0;
        bus0.in_valid   = 1'b0;
        bus0.in_data    = '0;
        bus0.coef_we    = 1'b0;
        bus0.coef_addr  = '0;
        bus0.coef_wdata = '0;
        bus0.out_ready  = 1'b1;
        modelReset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready0",  int'(bus0.in_ready),  1);
        checkOutput("reset busy0",      int'(bus0.busy),      0);
        checkOutput("reset out_valid0", int'(bus0.out_valid), 0);
        checkOutput("reset out_data0",  int'(bus0.out_data),  0);
        checkOutput("reset in_ready7",  int'(bus7.in_ready),  1);
        checkOutput("reset out_valid7", int'(bus7.out_valid), 0);
        rst = 1'b0;
        tick();

        // Impulse response with c[k] = k+1
        for (int k = 0; k < TAPS; k++) writeCoef(k, k + 1);
        for (int i = 0; i < 9; i++)
            applyStimulus(impulseTab[i].sample, 1'b1, impulseTab[i].exp0, impulseTab[i].exp7, 0, "impulse");

        // Positive and negative saturation with all coefficients at 127
        setAllCoefs(127);
        for (int i = 0; i < 8; i++)
            applyStimulus(satPosTab[i].sample, 1'b1, satPosTab[i].exp0, satPosTab[i].exp7, 0, "satpos");
        doFlush();
        for (int i = 0; i < 8; i++)
            applyStimulus(satNegTab[i].sample, 1'b1, satNegTab[i].exp0, satNegTab[i].exp7, 0, "satneg");

        // Round half up: only the newest tap has a weight of 64
        doFlush();
        setAllCoefs(0);
        writeCoef(0, 64);
        for (int i = 0; i < 6; i++)
            applyStimulus(roundTab[i].sample, 1'b1, roundTab[i].exp0, roundTab[i].exp7, 0, "round");

        // Backpressure: result held five cycles, upstream blocked meanwhile
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 8'sd1;
        modelAccept(1, e0, e7);
        tick();
        bus0.in_data = 8'sd55;
        st = 0;
        while (!bus0.out_valid && st < 40) begin
            tick();
            st++;
        end
        checkOutput("bp latency", st, TAPS);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("bp out_valid", int'(bus0.out_valid), 1);
            checkOutput("bp out_data0", int'(bus0.out_data), e0);
            checkOutput("bp out_data7", int'(bus7.out_data), e7);
            checkOutput("bp in_ready", int'(bus0.in_ready), 0);
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        tick();
        checkOutput("bp single transfer", int'(bus0.out_valid), 0);
        applyStimulus(8'sd55, 1'b0, 8'sd0, 8'sd0, 0, "bp resume");

        // Coefficient write while accumulating is dropped; in idle it lands
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'sd1;
        modelAccept(1, e0, e7);
        tick();
        bus0.in_valid = 1'b0;
        tick();
        bus0.coef_we    = 1'b1;
        bus0.coef_addr  = '0;
        bus0.coef_wdata = 8'sd100;
        tick();
        bus0.coef_we = 1'b0;
        while (!bus0.out_valid) tick();
        checkOutput("coef mid-mac out0", int'(bus0.out_data), e0);
        tick();
        applyStimulus(8'sd1, 1'b0, 8'sd0, 8'sd0, 0, "coef ignored");
        writeCoef(0, 100);
        applyStimulus(8'sd1, 1'b0, 8'sd0, 8'sd0, 0, "coef idle");

        // Write and accept in the same cycle: the new coefficient applies
        bus0.coef_we    = 1'b1;
        bus0.coef_addr  = '0;
        bus0.coef_wdata = -8'sd50;
        mCoef[0]        = -50;
        applyStimulus(8'sd2, 1'b0, 8'sd0, 8'sd0, 0, "coef same cycle");

        // Flush three cycles into accumulation, then history must be empty
        writeCoef(3, 20);
        startAndAdvance(8'sd9);
        doFlush();
        checkOutput("flush busy", int'(bus0.busy), 0);
        expectNoOutput("flush");
        applyStimulus(8'sd3, 1'b0, 8'sd0, 8'sd0, 0, "post flush");

        // Flush beats a simultaneous sample offer
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'sd7;
        doFlush();
        bus0.in_valid = 1'b0;
        checkOutput("flush blocks accept", int'(bus0.busy), 0);

        // Asynchronous reset mid-accumulation clears coefficients and history
        startAndAdvance(-8'sd20);
        rst = 1'b1;
        #1;
        checkOutput("async rst busy", int'(bus0.busy), 0);
        checkOutput("async rst out_data", int'(bus7.out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        tick();
        expectNoOutput("reset");
        applyStimulus(8'sd100, 1'b0, 8'sd0, 8'sd0, 0, "post reset zero coef");
        writeCoef(0, 5);
        applyStimulus(-8'sd7, 1'b0, 8'sd0, 8'sd0, 0, "post reset");

        // Randomized traffic against the reference model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0)
                writeCoef($urandom_range(0, TAPS - 1), int'($signed(8'($urandom_range(0, 255)))));
            rd = 8'($urandom_range(0, 255));
            st = $urandom_range(0, 3);
            applyStimulus(rd, 1'b0, 8'sd0, 8'sd0, st, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
